// File: rtl/ldpc_3gpp_dec_cnode_p_nway_search.sv
// Check-node partial-minimum search: pWAYS lanes merged through a registered
// binary tree, then folded across the beats of an isop/ieop frame.
module ldpc_3gpp_dec_cnode_p_nway_search #(
   parameter int pLLR_W = 4,
   parameter int pCOL_W = 5,
   parameter int pWAYS  = 4
) (
   input  logic                      iclk,
   input  logic                      ireset,
   input  logic                      iclkena,
   input  logic                      ival,
   input  logic                      isop,
   input  logic                      ieop,
   input  logic [pWAYS-1:0]          imask,
   input  logic [pWAYS*pLLR_W-1:0]   ivn_min1,
   input  logic [pWAYS*pLLR_W-1:0]   ivn_min2,
   input  logic [pWAYS*pCOL_W-1:0]   ivn_col,
   output logic                      oval,
   output logic [pLLR_W-1:0]         omin1,
   output logic [pLLR_W-1:0]         omin2,
   output logic [pCOL_W-1:0]         omin1_col
);

   localparam int cSTAGES = $clog2(pWAYS);

   typedef struct packed {
      logic [pLLR_W-1:0] min1;
      logic [pLLR_W-1:0] min2;
      logic [pCOL_W-1:0] col;
   } cand_t;

   localparam cand_t cIDLE = '{{pLLR_W{1'b1}}, {pLLR_W{1'b1}}, {pCOL_W{1'b0}}};

   // Two-way merge; the a-side keeps priority on equal values.
   function automatic cand_t merge(input cand_t a, input cand_t c);
      cand_t r;
      if (c.min1 < a.min1) begin
         r.min1 = c.min1;
         r.min2 = (c.min2 < a.min1) ? c.min2 : a.min1;
         r.col  = c.col;
      end else begin
         r.min1 = a.min1;
         r.min2 = (c.min1 < a.min2) ? c.min1 : a.min2;
         r.col  = a.col;
      end
      return r;
   endfunction

   // Level 0 holds the masked lane inputs; level j holds pWAYS>>j merge results.
   cand_t              tree_p [0:cSTAGES][pWAYS];
   logic [cSTAGES:0]   vld_p;
   logic [cSTAGES:0]   sop_p;
   logic [cSTAGES:0]   eop_p;
   cand_t              acc;

   // stage 0 input capture, stages 1..cSTAGES merge tree
   always_ff @(posedge iclk) begin
      if (iclkena) begin
         for (int k = 0; k < pWAYS; k++) begin
            if (imask[k])
               tree_p[0][k] <= {ivn_min1[k*pLLR_W +: pLLR_W],
                                ivn_min2[k*pLLR_W +: pLLR_W],
                                ivn_col[k*pCOL_W +: pCOL_W]};
            else
               tree_p[0][k] <= cIDLE;
         end
         for (int j = 1; j <= cSTAGES; j++) begin
            for (int i = 0; i < (pWAYS >> j); i++) begin
               tree_p[j][i] <= merge(tree_p[j-1][2*i], tree_p[j-1][2*i+1]);
            end
         end
      end
   end

   // control pipe aligned with the tree, then the frame accumulator
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         vld_p <= '0;
         sop_p <= '0;
         eop_p <= '0;
         oval  <= 1'b0;
         acc   <= cIDLE;
      end else if (iclkena) begin
         vld_p <= {vld_p[cSTAGES-1:0], ival};
         sop_p <= {sop_p[cSTAGES-1:0], ival & isop};
         eop_p <= {eop_p[cSTAGES-1:0], ival & ieop};
         oval  <= vld_p[cSTAGES] & eop_p[cSTAGES];
         if (vld_p[cSTAGES]) begin
            if (sop_p[cSTAGES])
               acc <= tree_p[cSTAGES][0];
            else
               acc <= merge(acc, tree_p[cSTAGES][0]);
         end
      end
   end

   assign omin1     = acc.min1;
   assign omin2     = acc.min2;
   assign omin1_col = acc.col;

endmodule

// File: tb/tb_ldpc_3gpp_dec_cnode_p_nway_search.sv
// Scoreboard bench for the n-way check-node minimum search (4 lanes).
module tb_ldpc_3gpp_dec_cnode_p_nway_search;

   localparam int W  = 4;
   localparam int LW = 4;
   localparam int CW = 5;

   typedef logic [2*LW+CW-1:0] res_t;

   logic              iclk = 1'b0;
   logic              ireset = 1'b1;
   logic              iclkena = 1'b1;
   logic              ival = 1'b0;
   logic              isop = 1'b0;
   logic              ieop = 1'b0;
   logic [W-1:0]      imask = '0;
   logic [W*LW-1:0]   ivn_min1 = '0;
   logic [W*LW-1:0]   ivn_min2 = '0;
   logic [W*CW-1:0]   ivn_col = '0;
   logic              oval;
   logic [LW-1:0]     omin1;
   logic [LW-1:0]     omin2;
   logic [CW-1:0]     omin1_col;

   ldpc_3gpp_dec_cnode_p_nway_search #(.pLLR_W(LW), .pCOL_W(CW), .pWAYS(W)) dut (
      .iclk      (iclk),
      .ireset    (ireset),
      .iclkena   (iclkena),
      .ival      (ival),
      .isop      (isop),
      .ieop      (ieop),
      .imask     (imask),
      .ivn_min1  (ivn_min1),
      .ivn_min2  (ivn_min2),
      .ivn_col   (ivn_col),
      .oval      (oval),
      .omin1     (omin1),
      .omin2     (omin2),
      .omin1_col (omin1_col)
   );

   always #5 iclk = ~iclk;

   int   total = 0;
   int   bad = 0;
   res_t exp_q [$];
   bit   rand_en = 1'b0;
   bit   en_s = 1'b0;

   logic [W-1:0]  fmask [8];
   logic [LW-1:0] fm1 [8][W];
   logic [LW-1:0] fm2 [8][W];
   logic [CW-1:0] fcol [8][W];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge iclk) en_s <= iclkena;

   // output monitor: pops one expectation per updated result, checks freeze
   initial begin
      res_t e;
      bit have_prev = 1'b0;
      logic [LW-1:0] p_m1, p_m2;
      logic [CW-1:0] p_col;
      logic p_val;
      forever begin
         @(negedge iclk);
         if (!ireset) begin
            if (en_s) begin
               if (oval) begin
                  if (exp_q.size() == 0) chk("unexpected_oval", 1, 0);
                  else begin
                     e = exp_q.pop_front();
                     chk("min1", omin1, e[2*LW+CW-1 -: LW]);
                     chk("min2", omin2, e[LW+CW-1 -: LW]);
                     chk("col", omin1_col, e[CW-1:0]);
                  end
               end
            end else if (have_prev) begin
               chk("hold_oval", oval, p_val);
               chk("hold_min1", omin1, p_m1);
               chk("hold_min2", omin2, p_m2);
               chk("hold_col", omin1_col, p_col);
            end
         end
         p_val = oval; p_m1 = omin1; p_m2 = omin2; p_col = omin1_col;
         have_prev = 1'b1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic set_beat(input int b, input logic [W-1:0] m,
                           input logic [W*LW-1:0] a1, input logic [W*LW-1:0] a2,
                           input logic [W*CW-1:0] c);
      fmask[b] = m;
      for (int k = 0; k < W; k++) begin
         fm1[b][k]  = a1[k*LW +: LW];
         fm2[b][k]  = a2[k*LW +: LW];
         fcol[b][k] = c[k*CW +: CW];
      end
   endtask

   task automatic fill_rand(input int nb);
      int hi;
      for (int b = 0; b < nb; b++) begin
         fmask[b] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         hi = ($urandom_range(0, 1) == 0) ? 5 : 15;
         for (int k = 0; k < W; k++) begin
            fm1[b][k]  = LW'($urandom_range(0, hi));
            fm2[b][k]  = fm1[b][k] + LW'($urandom_range(0, 15 - int'(fm1[b][k])));
            fcol[b][k] = CW'($urandom_range(0, 31));
         end
      end
   endtask

   task automatic pick_en();
      iclkena = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   endtask

   task automatic idle_cycle();
      ival = 1'b0; isop = 1'b0; ieop = 1'b0;
      pick_en();
      @(posedge iclk); #1;
   endtask

   // presents beat b and holds it until an enabled edge samples it
   task automatic drive_beat(input bit s, input bit e, input int b);
      bit taken;
      imask = fmask[b];
      for (int k = 0; k < W; k++) begin
         ivn_min1[k*LW +: LW] = fm1[b][k];
         ivn_min2[k*LW +: LW] = fm2[b][k];
         ivn_col[k*CW +: CW]  = fcol[b][k];
      end
      ival = 1'b1; isop = s; ieop = e;
      do begin
         pick_en();
         @(posedge iclk);
         taken = iclkena;
         #1;
      end while (!taken);
      ival = 1'b0; isop = 1'b0; ieop = 1'b0;
   endtask

   // gaps: 0 none, 1 forced 1..2 idle cycles between beats, 2 random 0..2
   task automatic send_frame(input int nb, input int gaps, input bit use_exp, input res_t exp);
      int best = 16;
      logic [LW-1:0] s1 = '1, s2 = '1, v1, v2;
      logic [CW-1:0] bc = '0, c;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < W; k++) begin
            v1 = fmask[b][k] ? fm1[b][k] : '1;
            v2 = fmask[b][k] ? fm2[b][k] : '1;
            c  = fmask[b][k] ? fcol[b][k] : '0;
            if (int'(v1) < best) begin best = int'(v1); bc = c; end
            if (v1 < s1) begin s2 = s1; s1 = v1; end else if (v1 < s2) s2 = v1;
            if (v2 < s1) begin s2 = s1; s1 = v2; end else if (v2 < s2) s2 = v2;
         end
      end
      exp_q.push_back(use_exp ? exp : {LW'(best), s2, bc});
      for (int b = 0; b < nb; b++) begin
         if (b > 0 && gaps == 1) repeat ($urandom_range(1, 2)) idle_cycle();
         if (b > 0 && gaps == 2) repeat ($urandom_range(0, 2)) idle_cycle();
         drive_beat(b == 0, b == nb - 1, b);
      end
   endtask

   task automatic drain();
      int n = 0;
      rand_en = 1'b0;
      iclkena = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge iclk); n++;
      end
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge iclk);
      #1;
      chk("rst_oval", oval, 0);
      chk("rst_min1", omin1, 15);
      chk("rst_min2", omin2, 15);
      chk("rst_col", omin1_col, 0);
      ireset = 1'b0;
      repeat (2) idle_cycle();

      // single beat, latency check
      set_beat(0, 4'b1111, {4'd9, 4'd5, 4'd3, 4'd7}, {4'd9, 4'd5, 4'd6, 4'd8},
               {5'd3, 5'd2, 5'd1, 5'd0});
      send_frame(1, 0, 1, {4'd3, 4'd5, 5'd1});
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge iclk);
         chk("latency_oval", oval, (cyc == 3) ? 1 : 0);
      end
      drain();

      // lane tie: lowest lane wins, min2 takes the tied value
      set_beat(0, 4'b1111, {4'd7, 4'd2, 4'd9, 4'd2}, {4'd8, 4'd4, 4'd9, 4'd4},
               {5'd7, 5'd6, 5'd5, 5'd4});
      send_frame(1, 0, 1, {4'd2, 4'd2, 5'd4});

      // beat tie: earlier beat wins
      set_beat(0, 4'b1111, {4'd12, 4'd12, 4'd2, 4'd12}, {4'd12, 4'd12, 4'd6, 4'd12},
               {5'd0, 5'd0, 5'd10, 5'd0});
      set_beat(1, 4'b1111, {4'd12, 4'd12, 4'd12, 4'd2}, {4'd12, 4'd12, 4'd12, 4'd3},
               {5'd0, 5'd0, 5'd0, 5'd20});
      send_frame(2, 0, 1, {4'd2, 4'd2, 5'd10});
      drain();

      // 3 beats with gaps, beat1 masked to lanes 0 and 2
      set_beat(0, 4'b1111, {4'd11, 4'd10, 4'd8, 4'd9}, {4'd14, 4'd13, 4'd9, 4'd12},
               {5'd3, 5'd2, 5'd1, 5'd0});
      set_beat(1, 4'b0101, {4'd1, 4'd4, 4'd0, 4'd5}, {4'd2, 4'd7, 4'd0, 4'd6},
               {5'd7, 5'd6, 5'd5, 5'd4});
      set_beat(2, 4'b1111, {4'd9, 4'd8, 4'd7, 4'd6}, {4'd10, 4'd9, 4'd8, 4'd7},
               {5'd11, 5'd10, 5'd9, 5'd8});
      send_frame(3, 1, 0, '0);
      drain();

      // back-to-back frames, second frame larger than the first
      set_beat(0, 4'b1111, {4'd6, 4'd5, 4'd4, 4'd1}, {4'd7, 4'd6, 4'd5, 4'd2},
               {5'd4, 5'd3, 5'd2, 5'd1});
      send_frame(1, 0, 1, {4'd1, 4'd2, 5'd1});
      set_beat(0, 4'b1111, {4'd11, 4'd10, 4'd12, 4'd9}, {4'd12, 4'd10, 4'd14, 4'd13},
               {5'd4, 5'd3, 5'd2, 5'd1});
      send_frame(1, 0, 1, {4'd9, 4'd10, 5'd1});
      drain();

      // all lanes masked
      fill_rand(2);
      fmask[0] = '0; fmask[1] = '0;
      send_frame(2, 0, 1, {4'd15, 4'd15, 5'd0});
      drain();

      // random clock enable mid-frame
      rand_en = 1'b1;
      for (int f = 0; f < 150; f++) begin
         int nb = $urandom_range(1, 8);
         fill_rand(nb);
         send_frame(nb, 2, 0, '0);
      end
      drain();

      // reset in the middle of a frame
      fill_rand(3);
      drive_beat(1'b1, 1'b0, 0);
      drive_beat(1'b0, 1'b0, 1);
      #2;
      ireset = 1'b1;
      #1;
      chk("mid_rst_oval", oval, 0);
      chk("mid_rst_min1", omin1, 15);
      chk("mid_rst_min2", omin2, 15);
      chk("mid_rst_col", omin1_col, 0);
      @(posedge iclk); #1;
      ireset = 1'b0;
      repeat (6) idle_cycle();
      fill_rand(3);
      send_frame(3, 2, 0, '0);
      drain();

      // random regression
      for (int f = 0; f < 2000; f++) begin
         int nb = $urandom_range(1, 8);
         rand_en = ($urandom_range(0, 9) == 0);
         fill_rand(nb);
         send_frame(nb, ($urandom_range(0, 2) == 0) ? 2 : 0, 0, '0);
      end
      drain();
      repeat (5) idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
